// File: rtl/axis_frame_len_arb.sv
// Round-robin funnel of per-port frame-length reports into one registered valid/ready stream.
// Each port keeps one pending report; reports that find their slot occupied are dropped and counted.
module axis_frame_len_arb #(
    parameter int PORTS          = 4,
    parameter int LEN_WIDTH      = 16,
    parameter int PORT_WIDTH     = $clog2(PORTS),
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*LEN_WIDTH-1:0]  in_frame_len,
    input  logic [PORTS-1:0]            in_frame_len_valid,
    output logic [LEN_WIDTH-1:0]        out_frame_len,
    output logic [PORT_WIDTH-1:0]       out_port,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PORTS-1:0]            drop,
    output logic [DROP_CNT_WIDTH-1:0]   drop_count
);

    localparam int NUM_W = $clog2(PORTS + 1);
    localparam int EXT_W = DROP_CNT_WIDTH + NUM_W;

    logic [LEN_WIDTH-1:0]  hold_len [PORTS];
    logic [PORTS-1:0]      hold_valid;
    logic [PORT_WIDTH-1:0] rr_ptr;

    logic                  out_load;
    logic                  grant_any;
    logic                  grant_en;
    logic [PORT_WIDTH-1:0] grant_idx;
    logic [PORTS-1:0]      grant_oh;
    logic [PORT_WIDTH-1:0] scan_idx;
    logic [PORTS-1:0]      capture;
    logic [PORTS-1:0]      drop_now;
    logic [NUM_W-1:0]      drop_num;

    // Add this cycle's drops to the counter, pinning at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_WIDTH-1:0] sat_add(
        input logic [DROP_CNT_WIDTH-1:0] cnt,
        input logic [NUM_W-1:0]          num
    );
        logic [EXT_W-1:0] sum;
        sum = EXT_W'(cnt) + EXT_W'(num);
        if (sum[EXT_W-1:DROP_CNT_WIDTH] != '0)
            return '1;
        return sum[DROP_CNT_WIDTH-1:0];
    endfunction

    assign out_load = !out_valid || out_ready;
    assign grant_en = out_load && grant_any;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        scan_idx  = '0;
        for (int k = 0; k < PORTS; k++) begin
            scan_idx = PORT_WIDTH'((int'(rr_ptr) + k) % PORTS);
            if (!grant_any && hold_valid[scan_idx]) begin
                grant_any          = 1'b1;
                grant_idx          = scan_idx;
                grant_oh[scan_idx] = 1'b1;
            end
        end
    end

    // A slot is free if empty or if its occupant leaves for the output this cycle.
    always_comb begin
        capture  = '0;
        drop_now = '0;
        drop_num = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (in_frame_len_valid[i] && !rst) begin
                if (!hold_valid[i] || (grant_en && grant_oh[i]))
                    capture[i] = 1'b1;
                else
                    drop_now[i] = 1'b1;
            end
            drop_num = drop_num + NUM_W'(drop_now[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid    <= '0;
            rr_ptr        <= '0;
            out_valid     <= 1'b0;
            out_frame_len <= '0;
            out_port      <= '0;
            drop          <= '0;
            drop_count    <= '0;
        end else begin
            drop       <= drop_now;
            drop_count <= sat_add(drop_count, drop_num);
            for (int i = 0; i < PORTS; i++) begin
                if (capture[i])
                    hold_valid[i] <= 1'b1;
                else if (grant_en && grant_oh[i])
                    hold_valid[i] <= 1'b0;
            end
            if (out_load) begin
                if (grant_any) begin
                    out_frame_len <= hold_len[grant_idx];
                    out_port      <= grant_idx;
                    out_valid     <= 1'b1;
                    rr_ptr        <= (grant_idx == PORT_WIDTH'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // Holding stage data; only meaningful while the matching hold_valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (capture[i])
                hold_len[i] <= in_frame_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

endmodule

// File: doc/axis_frame_len_arb.md
# axis_frame_len_arb

Round-robin arbiter that funnels frame-length reports from `PORTS` independent `axis_frame_len` monitors into one registered valid/ready output stream. A single downstream statistics/logging resource can then consume the reports, each tagged with its source port. The arbiter sits between the per-port frame-length monitors and the shared stats accumulator. It holds one pending report per port and counts reports it has to drop because of backpressure.

## Interface
- `PORTS`, 4: number of monitored streams, ≥2.
- `LEN_WIDTH`, 16: frame length width; matches the monitor's `LEN_WIDTH`.
- `PORT_WIDTH`, `$clog2(PORTS)`: width of the source-port tag.
- `DROP_CNT_WIDTH`, 16: width of the saturating drop counter.

Ports (one clock, `clk`; reset `rst` is synchronous, active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `in_frame_len`  in  `PORTS*LEN_WIDTH`  per-port length; port i occupies bits `[i*LEN_WIDTH +: LEN_WIDTH]`.
- `in_frame_len_valid`  in  `PORTS`  per-port single-cycle report strobe; there is no ready, so the monitor cannot be stalled.
- `out_frame_len`  out  `LEN_WIDTH`  granted length.
- `out_port`  out  `PORT_WIDTH`  source index of `out_frame_len`.
- `out_valid`  out  1  output report valid.
- `out_ready`  in  1  downstream accept.
- `drop`  out  `PORTS`  one-cycle pulse per port when that port's report was discarded.
- `drop_count`  out  `DROP_CNT_WIDTH`  total drops across all ports; saturates at all-ones.

## Operation
- **Per-port holding stage:** each port has `hold_len[i]` and `hold_valid[i]`.
- **Capture:** on `in_frame_len_valid[i]`, the report is captured if either:
  - `hold_valid[i]==0`, or
  - port i is granted into the output stage in the same cycle.
  
  Capture sets `hold_valid[i]` and loads `hold_len[i]`.
- **Drop:** a report that cannot be captured is discarded. The existing held value is kept (oldest wins). `drop[i]` pulses in the next cycle and `drop_count` increments.
- **Multiple drops in one cycle:** `drop_count` adds the number of ports dropping in that cycle, saturating at `2^DROP_CNT_WIDTH-1`. The counter never wraps.
- **Output load condition:** the output stage loads when `out_valid==0 || out_ready`.
- **Grant:** when the output loads, the arbiter grants the first port with `hold_valid` set, searching from `rr_ptr` upward and wrapping modulo `PORTS`.
- **Grant effects:**
  - `out_frame_len <= hold_len[g]`, `out_port <= g`, `out_valid <= 1`.
  - `hold_valid[g]` clears, unless a new report for g is captured in the same cycle.
  - `rr_ptr <= (g+1) mod PORTS`.
- **No grant:** if the output loads but no port is pending, `out_valid <= 0` and `rr_ptr` is unchanged.
- **Stall:** while `out_valid && !out_ready`, `out_frame_len`, `out_port` and `out_valid` hold stable and no grant occurs.
- **Arbiter state:** `rr_ptr` (0..`PORTS-1`) plus the per-port `hold_valid` vector. There is no other FSM.

## Timing
- **Reset values:** `out_valid=0`, `out_frame_len=0`, `out_port=0`, `drop=0`, `drop_count=0`, all `hold_valid=0`, `rr_ptr=0`.
- **Reset mid-operation:** pending and in-flight reports are discarded and not counted as drops. An input strobe present during the `rst` cycle is ignored.
- **Latency:** strobe at cycle t → `hold_valid` at t+1 → `out_valid` at t+2 at the earliest, provided the output is free or `out_ready` is high at t+1.
- **Throughput:** one report per cycle under continuous `out_ready`.
- **Per-port capacity:** each port holds 1 entry, plus 1 shared entry in the output register. A port can accept one report per cycle only while it wins the grant every cycle.
- **Same-port capture and grant:** a strobe and a grant on the same port in the same cycle yields no drop, and the new value is retained.
- **Drop timing:** a drop at strobe cycle t gives `drop[i]` high at t+1 only, and `drop_count` updated at t+1.

## Test plan
- **Single report:** reset, then strobe port 2 with len=0x0040, `out_ready=1` → at t+2 `out_valid=1`, `out_frame_len=0x0040`, `out_port=2`, held for 1 cycle; then `out_valid=0`.
- **Round-robin order:** strobe all 4 ports simultaneously (lens 10, 20, 30, 40), `out_ready=1` → outputs ports 0, 1, 2, 3 on consecutive cycles. Then strobe ports 0 and 3 → order is 0, 3. Then strobe ports 0 and 1 with `rr_ptr=1` → order is 1, 0.
- **Backpressure and drop:** `out_ready=0`. Strobe port 1 three times (lens 5, 6, 7), one cycle apart → port 1's first report (len 5) advances into the idle output register, len 6 stays held, len 7 is dropped with `drop[1]` pulsing once and `drop_count=1`. Raise `out_ready` → outputs 5 then 6.
- **Same-cycle grant and capture:** keep port 0 strobing every cycle with `out_ready=1` and no other traffic → every value appears on the output in order and `drop_count` stays 0.
- **Drop counter saturation:** with `DROP_CNT_WIDTH=2`, `out_ready=0`, flood all ports → `drop_count` reaches 3 and stays there. A cycle with 4 simultaneous drops starting from count 2 → count becomes 3.
- **Reset mid-stream:** with pending entries on all ports and `out_valid=1`, assert `rst` for 1 cycle → next cycle all outputs are 0, and a subsequent strobe on port 3 is granted first from `rr_ptr=0`.
